fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter n, default 32, is the PC and address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-003 Parameter NOP, default 32'h0000_0013, is the instruction word placed in IF/ID on a bubble.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  holds the PC and the IF/ID register.
REQ-007 flush  input  1  inserts a bubble into IF/ID.
REQ-008 branch_taken  input  1  redirects the PC to branch_target.
REQ-009 branch_target  input  n  redirect address.
REQ-010 imem_addr  output  n  instruction memory address, equal to the current PC.
REQ-011 imem_rdata  input  32  instruction word, combinational from imem_addr in the same cycle.
REQ-012 if_pc  output  n  PC of the instruction held in IF/ID.
REQ-013 if_pc_plus4  output  n  if_pc + 4, modulo 2^n.
REQ-014 if_instr  output  32  instruction held in IF/ID.
REQ-015 if_valid  output  1  IF/ID holds a real instruction; 0 means a bubble.

Function
REQ-016 imem_addr shall equal the PC register combinationally, with no added latency.
REQ-017 next_pc shall be branch_target with bits [1:0] forced to 0 when branch_taken=1, else PC + 4, wrapping modulo 2^n.
REQ-018 On each rising edge without rst, PC shall load next_pc if branch_taken=1 or stall=0, and otherwise hold.
REQ-019 branch_taken shall override stall: the redirect is never lost while stalled.
REQ-020 IF/ID shall load {PC, PC+4, imem_rdata, valid=1} on an edge where stall=0, flush=0 and branch_taken=0.
REQ-021 IF/ID shall load a bubble {if_pc=0, if_pc_plus4=0, if_instr=NOP, if_valid=0} on an edge where flush=1 or branch_taken=1, regardless of stall.
REQ-022 IF/ID shall hold all fields on an edge where stall=1, flush=0 and branch_taken=0.
REQ-023 Fetch-to-IF/ID latency shall be exactly one cycle: the word at imem_addr in cycle k appears on if_instr in cycle k+1.
REQ-024 With no stall, flush or branch, the PC shall advance by 4 every cycle, and PC = 2^n-4 shall wrap to 0.
REQ-025 The block shall contain no state other than the PC and IF/ID registers, and no FSM beyond the priority rst > branch_taken/flush > stall > advance.

Reset
REQ-026 While rst=1 at a rising edge, PC shall load RESET_PC and IF/ID shall load the bubble value of REQ-021.
REQ-027 rst shall override stall, flush and branch_taken on the same edge.
REQ-028 Reset asserted mid-stall or mid-redirect shall discard the pending state, and fetch shall restart from RESET_PC on the first edge after rst deasserts.
REQ-029 All outputs shall be defined (no X) from the first edge with rst=1.

Structure
REQ-030 The shared CPU package shall hold NOP, RESET_PC and the PC increment constant 4.
REQ-031 Next-PC selection shall instantiate the existing Mux2x1 with n=n: i0=PC+4, i1=aligned branch_target, sel=branch_taken.
REQ-032 The IF/ID register shall be a single always block within this module, with no further sub-module.

Verification
REQ-033 Reset then run: rst high 2 cycles, imem returns the address as data -> imem_addr=0,4,8,...; if_instr lags by one cycle; if_valid=1 from the second cycle after reset.
REQ-034 Stall: stall=1 for 3 cycles at PC=0x10 -> imem_addr stays 0x10; if_instr/if_pc frozen at the 0x0C entry; advance resumes to 0x14.
REQ-035 Branch under stall: stall=1, branch_taken=1, target=0x103 -> next PC=0x100 and if_valid=0 with if_instr=0x00000013.
REQ-036 Flush+stall: flush=1, stall=1 at PC=0x20 -> if_valid=0 and PC holds 0x20.
REQ-037 Wrap and mid-op reset: with n=8, PC=0xFC advances to 0x00; rst during stall -> PC=RESET_PC and bubble on the next edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants used by the fetch stage: bubble instruction, reset PC
// and the sequential PC increment.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/fetch_stage_mux2x1.sv
// Generic two-input multiplexer, n bits wide; sel=1 selects i1.
module Mux2x1 #(
    parameter int n = 32
) (
    input  logic [n-1:0] i0,
    input  logic [n-1:0] i1,
    input  logic         sel,
    output logic [n-1:0] y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register with stall, flush and branch-redirect handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          n        = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         branch_taken,
    input  logic [n-1:0] branch_target,
    output logic [n-1:0] imem_addr,
    input  logic [31:0]  imem_rdata,
    output logic [n-1:0] if_pc,
    output logic [n-1:0] if_pc_plus4,
    output logic [31:0]  if_instr,
    output logic         if_valid
);

    logic [n-1:0] r_pc;
    logic [n-1:0] w_pc_plus4;
    logic [n-1:0] w_target_aligned;
    logic [n-1:0] w_next_pc;
    logic         w_bubble;

    logic [n-1:0] r_if_pc;
    logic [n-1:0] r_if_pc_plus4;
    logic [31:0]  r_if_instr;
    logic         r_if_valid;

    // Increment wraps naturally at 2^n because the sum is truncated to n bits.
    assign w_pc_plus4       = r_pc + n'(PC_INC);
    assign w_target_aligned = branch_target & ~n'(3);
    assign w_bubble         = flush | branch_taken;

    Mux2x1 #(
        .n(n)
    ) u_next_pc_mux (
        .i0  (w_pc_plus4),
        .i1  (w_target_aligned),
        .sel (branch_taken),
        .y   (w_next_pc)
    );

    // A redirect must never be lost, so branch_taken advances the PC even under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= n'(RESET_PC);
        end else if (branch_taken || !stall) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
            r_if_instr    <= NOP;
            r_if_valid    <= 1'b0;
        end else if (!stall) begin
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_if_instr    <= imem_rdata;
            r_if_valid    <= 1'b1;
        end
    end

    assign imem_addr   = r_pc;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_instr    = r_if_instr;
    assign if_valid    = r_if_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 32-bit and an 8-bit instance share one directed
// control sequence; a behavioural model is checked every cycle plus literal points.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] a_target;
    logic [7:0]  b_target;

    logic [31:0] a_addr, a_rdata, a_if_pc, a_if_pc4, a_if_instr;
    logic        a_if_valid;
    logic [7:0]  b_addr, b_if_pc, b_if_pc4;
    logic [31:0] b_rdata, b_if_instr;
    logic        b_if_valid;

    int n_pass  = 0;
    int n_total = 0;

    // Instruction memory returns its own address as the data word.
    assign a_rdata  = a_addr;
    assign b_rdata  = {24'h0, b_addr};
    assign b_target = a_target[7:0];

    fetch_stage #(.n(32)) dut32 (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (a_target),
        .imem_addr     (a_addr),
        .imem_rdata    (a_rdata),
        .if_pc         (a_if_pc),
        .if_pc_plus4   (a_if_pc4),
        .if_instr      (a_if_instr),
        .if_valid      (a_if_valid)
    );

    fetch_stage #(.n(8)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (b_target),
        .imem_addr     (b_addr),
        .imem_rdata    (b_rdata),
        .if_pc         (b_if_pc),
        .if_pc_plus4   (b_if_pc4),
        .if_instr      (b_if_instr),
        .if_valid      (b_if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: index 0 is the 32-bit instance, index 1 the 8-bit one.
    longint unsigned m_pc   [2];
    longint unsigned m_ifpc [2];
    longint unsigned m_ifpc4[2];
    longint unsigned m_instr[2];
    bit              m_valid[2];
    bit              m_live = 1'b0;

    function automatic longint unsigned modulus(input int i);
        return (i == 0) ? 64'h1_0000_0000 : 64'h100;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            longint unsigned tgt;
            longint unsigned seq;
            tgt = (i == 0) ? longint'(a_target) : longint'(b_target);
            if (rst) begin
                m_pc[i]    = 0;
                m_ifpc[i]  = 0;
                m_ifpc4[i] = 0;
                m_instr[i] = 64'h13;
                m_valid[i] = 1'b0;
            end else begin
                seq = (m_pc[i] + 4) % modulus(i);
                if (flush || branch_taken) begin
                    m_ifpc[i]  = 0;
                    m_ifpc4[i] = 0;
                    m_instr[i] = 64'h13;
                    m_valid[i] = 1'b0;
                end else if (!stall) begin
                    m_ifpc[i]  = m_pc[i];
                    m_ifpc4[i] = seq;
                    m_instr[i] = m_pc[i];
                    m_valid[i] = 1'b1;
                end
                if (branch_taken)
                    m_pc[i] = tgt - (tgt % 4);
                else if (!stall)
                    m_pc[i] = seq;
            end
        end
        if (rst) m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m32_addr",   64'(a_addr),     m_pc[0]);
            check("m32_ifpc",   64'(a_if_pc),    m_ifpc[0]);
            check("m32_ifpc4",  64'(a_if_pc4),   m_ifpc4[0]);
            check("m32_instr",  64'(a_if_instr), m_instr[0]);
            check("m32_valid",  64'(a_if_valid), 64'(m_valid[0]));
            check("m8_addr",    64'(b_addr),     m_pc[1]);
            check("m8_ifpc",    64'(b_if_pc),    m_ifpc[1]);
            check("m8_ifpc4",   64'(b_if_pc4),   m_ifpc4[1]);
            check("m8_instr",   64'(b_if_instr), m_instr[1]);
            check("m8_valid",   64'(b_if_valid), 64'(m_valid[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; a_target = '0;
        tick(); tick();
        check("rst_addr",  64'(a_addr),     64'h0);
        check("rst_valid", 64'(a_if_valid), 64'h0);
        check("rst_instr", 64'(a_if_instr), 64'h13);

        rst = 1'b0;
        tick();
        check("run1_addr",  64'(a_addr),     64'h4);
        check("run1_valid", 64'(a_if_valid), 64'h1);
        check("run1_instr", 64'(a_if_instr), 64'h0);
        tick(); tick(); tick();
        check("run4_addr",  64'(a_addr),     64'h10);
        check("run4_ifpc",  64'(a_if_pc),    64'h0C);
        check("run4_instr", 64'(a_if_instr), 64'h0C);
        check("run4_pc4",   64'(a_if_pc4),   64'h10);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_addr", 64'(a_addr),     64'h10);
            check("stall_ifpc", 64'(a_if_pc),    64'h0C);
            check("stall_inst", 64'(a_if_instr), 64'h0C);
        end
        stall = 1'b0;
        tick();
        check("resume_addr", 64'(a_addr),  64'h14);
        check("resume_ifpc", 64'(a_if_pc), 64'h10);

        stall = 1'b1; branch_taken = 1'b1; a_target = 32'h103;
        tick();
        check("brst_addr",  64'(a_addr),     64'h100);
        check("brst_valid", 64'(a_if_valid), 64'h0);
        check("brst_instr", 64'(a_if_instr), 64'h13);
        check("brst_ifpc",  64'(a_if_pc),    64'h0);
        check("brst8_addr", 64'(b_addr),     64'h0);
        stall = 1'b0; branch_taken = 1'b0;
        tick();
        check("postbr_addr", 64'(a_addr),  64'h104);
        check("postbr_ifpc", 64'(a_if_pc), 64'h100);

        branch_taken = 1'b1; a_target = 32'h20;
        tick();
        branch_taken = 1'b0; flush = 1'b1; stall = 1'b1;
        tick();
        check("flst_valid", 64'(a_if_valid), 64'h0);
        check("flst_addr",  64'(a_addr),     64'h20);
        flush = 1'b0; stall = 1'b0;
        tick();
        check("flrun_addr", 64'(a_addr),  64'h24);
        check("flrun_ifpc", 64'(a_if_pc), 64'h20);
        flush = 1'b1;
        tick();
        check("fl_addr",  64'(a_addr),     64'h28);
        check("fl_valid", 64'(a_if_valid), 64'h0);
        flush = 1'b0;

        stall = 1'b1;
        tick(); tick();
        check("pre_rst_addr", 64'(a_addr), 64'h28);
        rst = 1'b1;
        tick();
        check("rststall_addr",  64'(a_addr),     64'h0);
        check("rststall_valid", 64'(a_if_valid), 64'h0);
        rst = 1'b0; stall = 1'b0;
        tick();
        check("restart_addr",  64'(a_addr),     64'h4);
        check("restart_ifpc",  64'(a_if_pc),    64'h0);
        check("restart_valid", 64'(a_if_valid), 64'h1);

        rst = 1'b1; branch_taken = 1'b1; a_target = 32'h200;
        tick();
        check("rstbr_addr", 64'(a_addr), 64'h0);
        rst = 1'b0; branch_taken = 1'b0;
        tick();
        check("rstbr_next", 64'(a_addr), 64'h4);

        branch_taken = 1'b1; a_target = 32'hF8;
        tick();
        branch_taken = 1'b0;
        tick();
        check("wrap8_fc", 64'(b_addr), 64'hFC);
        tick();
        check("wrap8_addr", 64'(b_addr),   64'h00);
        check("wrap8_ifpc", 64'(b_if_pc),  64'hFC);
        check("wrap8_pc4",  64'(b_if_pc4), 64'h00);
        check("nowrap32",   64'(a_addr),   64'h100);

        branch_taken = 1'b1; a_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        check("wrap32_addr", 64'(a_addr),   64'h0);
        check("wrap32_pc4",  64'(a_if_pc4), 64'h0);
        check("wrap32_ifpc", 64'(a_if_pc),  64'hFFFF_FFFC);
        tick(); tick();

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
